// File: rtl/ovc_credit_tracker.sv
// Output-port tracker: per-VC downstream credit counters, allocation state,
// derived status flags and a sticky first-error latch.
module ovc_credit_tracker #(
    parameter int V              = 4,
    parameter int B              = 4,
    parameter int CREDITw        = $clog2(B + 1),
    parameter int NEARLY_FULL_TH = 1,
    parameter int CRDT_INIT_EN   = 1,
    parameter int OVC_ALLOC_MODE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [V*CREDITw-1:0]   credit_init_val_i,
    input  logic [V-1:0]           hetero_ovc_presence_i,
    input  logic                   flit_wr_i,
    input  logic [V-1:0]           flit_vc_i,
    input  logic [V-1:0]           credit_in_i,
    input  logic [V-1:0]           ovc_allocate_i,
    input  logic [V-1:0]           ovc_release_i,
    output logic [V*CREDITw-1:0]   credit_o,
    output logic [V-1:0]           status_o,
    output logic [V-1:0]           full_o,
    output logic [V-1:0]           nearly_full_o,
    output logic [V-1:0]           empty_o,
    output logic [V-1:0]           avalable_o,
    output logic                   err_o,
    output logic [2:0]             err_code_o
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ALLOC = 1'b1
    } state_t;

    localparam logic [CREDITw-1:0] LP_B     = CREDITw'(B);
    localparam logic [CREDITw-1:0] LP_ZERO  = '0;
    localparam logic [CREDITw-1:0] LP_NF_TH = CREDITw'(NEARLY_FULL_TH);

    localparam logic [2:0] ERR_UNDERFLOW = 3'd1;
    localparam logic [2:0] ERR_OVERFLOW  = 3'd2;
    localparam logic [2:0] ERR_VC_ONEHOT = 3'd3;
    localparam logic [2:0] ERR_ABSENT    = 3'd4;
    localparam logic [2:0] ERR_DBL_ALLOC = 3'd5;
    localparam logic [2:0] ERR_REL_IDLE  = 3'd6;

    logic         w_vc_onehot;
    logic         w_wr_ok;
    logic         w_wr_bad;
    logic [V-1:0] w_err_udf;
    logic [V-1:0] w_err_ovf;
    logic [V-1:0] w_err_abs;
    logic [V-1:0] w_err_dalloc;
    logic [V-1:0] w_err_rel;
    logic         w_any_err;
    logic [2:0]   w_err_code;

    logic         r_err;
    logic [2:0]   r_err_code;

    // A malformed VC select suppresses the write on every VC.
    assign w_vc_onehot = (flit_vc_i != '0) && ((flit_vc_i & (flit_vc_i - 1'b1)) == '0);
    assign w_wr_ok     = flit_wr_i & w_vc_onehot;
    assign w_wr_bad    = flit_wr_i & ~w_vc_onehot;

    generate
        for (genvar gi = 0; gi < V; gi++) begin : g_vc
            logic [CREDITw-1:0] r_credit;
            logic [CREDITw-1:0] r_credit_max;
            logic               r_present;
            state_t             r_state;

            logic [CREDITw-1:0] w_init;
            logic [CREDITw-1:0] w_init_clip;
            logic               w_dec;
            logic               w_inc;
            logic               w_alloc;
            logic               w_rel;
            logic               w_at_zero;
            logic               w_at_max;
            logic               w_full;
            logic               w_nfull;

            assign w_init      = credit_init_val_i[gi*CREDITw +: CREDITw];
            assign w_init_clip = (CRDT_INIT_EN != 0) ? ((w_init > LP_B) ? LP_B : w_init) : LP_B;

            assign w_dec     = w_wr_ok & flit_vc_i[gi];
            assign w_inc     = credit_in_i[gi];
            assign w_alloc   = ovc_allocate_i[gi];
            assign w_rel     = ovc_release_i[gi];
            assign w_at_zero = (r_credit == LP_ZERO);
            assign w_at_max  = (r_credit == r_credit_max);

            assign w_err_udf[gi]    = r_present & w_dec & ~w_inc & w_at_zero;
            assign w_err_ovf[gi]    = r_present & w_inc & ~w_dec & w_at_max;
            assign w_err_abs[gi]    = ~r_present & (w_dec | w_inc | w_alloc | w_rel);
            assign w_err_dalloc[gi] = r_present & (r_state == ST_ALLOC) & w_alloc & ~w_rel;
            assign w_err_rel[gi]    = r_present & (r_state == ST_IDLE) & w_rel;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_present <= hetero_ovc_presence_i[gi];
                    if (!hetero_ovc_presence_i[gi]) begin
                        r_credit     <= LP_ZERO;
                        r_credit_max <= LP_ZERO;
                    end else if (w_init_clip == LP_ZERO) begin
                        // Zero init: buffer starts occupied, credits arrive later.
                        r_credit     <= LP_ZERO;
                        r_credit_max <= LP_B;
                    end else begin
                        r_credit     <= w_init_clip;
                        r_credit_max <= w_init_clip;
                    end
                end else if (r_present) begin
                    case ({w_inc, w_dec})
                        2'b10: if (!w_at_max)  r_credit <= r_credit + 1'b1;
                        2'b01: if (!w_at_zero) r_credit <= r_credit - 1'b1;
                        default: r_credit <= r_credit;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_state <= ST_IDLE;
                end else if (r_present) begin
                    case (r_state)
                        ST_IDLE:  if (w_alloc) r_state <= ST_ALLOC;
                        ST_ALLOC: if (w_rel && !w_alloc) r_state <= ST_IDLE;
                        default:  r_state <= ST_IDLE;
                    endcase
                end
            end

            assign w_full  = ~r_present | w_at_zero;
            assign w_nfull = (r_credit <= LP_NF_TH);

            assign credit_o[gi*CREDITw +: CREDITw] = r_credit;
            assign status_o[gi]      = (r_state == ST_ALLOC);
            assign full_o[gi]        = w_full;
            assign nearly_full_o[gi] = w_nfull;
            assign empty_o[gi]       = ~r_present | w_at_max;
            assign avalable_o[gi]    = r_present & (r_state == ST_IDLE) &
                                       ((OVC_ALLOC_MODE != 0) ? ~w_full : ~w_nfull);
        end
    endgenerate

    assign w_any_err = (|w_err_udf) | (|w_err_ovf) | w_wr_bad |
                       (|w_err_abs) | (|w_err_dalloc) | (|w_err_rel);

    always_comb begin
        w_err_code = 3'd0;
        if (|w_err_udf)         w_err_code = ERR_UNDERFLOW;
        else if (|w_err_ovf)    w_err_code = ERR_OVERFLOW;
        else if (w_wr_bad)      w_err_code = ERR_VC_ONEHOT;
        else if (|w_err_abs)    w_err_code = ERR_ABSENT;
        else if (|w_err_dalloc) w_err_code = ERR_DBL_ALLOC;
        else if (|w_err_rel)    w_err_code = ERR_REL_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err      <= 1'b0;
            r_err_code <= 3'd0;
        end else if (!r_err && w_any_err) begin
            r_err      <= 1'b1;
            r_err_code <= w_err_code;
        end
    end

    assign err_o      = r_err;
    assign err_code_o = r_err_code;

endmodule
